// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding memory request, 2-entry
// instruction buffer toward decode, flush/redirect from CONTROL.
module fetch_unit #(
   parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
   parameter int          BUF_DEPTH  = 2
) (
   input  logic        clock_in,
   input  logic        reset_in,
   input  logic        flush_in,
   input  logic [31:0] flush_addr_in,
   output logic        mem_req_out,
   output logic [31:0] mem_addr_out,
   input  logic        mem_gnt_in,
   input  logic        mem_rvalid_in,
   input  logic [31:0] mem_rdata_in,
   output logic        id_valid_out,
   output logic [31:0] id_inst_out,
   output logic [31:0] id_pc_out,
   input  logic        id_ready_in
);

   // Only a depth of 2 is supported; pointers are one bit and wrap naturally.
   localparam logic [1:0] LP_DEPTH = BUF_DEPTH[1:0];

   typedef enum logic [1:0] {S_REQ, S_WAIT, S_DISCARD} state_t;

   state_t      r_state, w_state_nxt;
   logic [31:0] r_pc, r_pend_pc;
   logic [1:0]  r_count;
   logic        r_head, r_tail;
   logic [31:0] r_buf_inst [0:1];
   logic [31:0] r_buf_pc   [0:1];

   logic        w_req, w_acc, w_push, w_pop;
   logic [31:0] w_flush_pc;

   // Redirect target is forced word aligned.
   assign w_flush_pc = flush_addr_in & 32'hFFFF_FFFC;

   // Request only from REQ with buffer room; never from the old pc during
   // a flush, and never while reset is held.
   assign w_req  = (r_state == S_REQ) && (r_count < LP_DEPTH) && !flush_in && !reset_in;
   assign w_acc  = w_req && mem_gnt_in;
   assign w_push = (r_state == S_WAIT) && mem_rvalid_in && !flush_in;
   assign w_pop  = (r_count != 2'd0) && id_ready_in;

   assign mem_req_out  = w_req;
   assign mem_addr_out = r_pc;
   assign id_valid_out = (r_count != 2'd0);
   assign id_inst_out  = r_buf_inst[r_head];
   assign id_pc_out    = r_buf_pc[r_head];

   // State register.
   always_ff @(posedge clock_in or posedge reset_in) begin
      if (reset_in) r_state <= S_REQ;
      else          r_state <= w_state_nxt;
   end

   // Next-state logic. A grant seen in REQ during a flush is treated as a
   // possibly accepted request, so its response must be swallowed in DISCARD.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_REQ: begin
            if (flush_in)   w_state_nxt = mem_gnt_in ? S_DISCARD : S_REQ;
            else if (w_acc) w_state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (mem_rvalid_in) w_state_nxt = S_REQ;
            else if (flush_in) w_state_nxt = S_DISCARD;
         end
         S_DISCARD: begin
            if (mem_rvalid_in) w_state_nxt = S_REQ;
         end
         default: w_state_nxt = S_REQ;
      endcase
   end

   // Fetch pc and the pc of the outstanding request.
   always_ff @(posedge clock_in or posedge reset_in) begin
      if (reset_in) begin
         r_pc      <= RESET_ADDR;
         r_pend_pc <= 32'h0;
      end else if (flush_in) begin
         r_pc <= w_flush_pc;
      end else if (w_acc) begin
         r_pend_pc <= r_pc;
         r_pc      <= r_pc + 32'd4;
      end
   end

   // Instruction buffer pointers and occupancy; flush empties it.
   always_ff @(posedge clock_in or posedge reset_in) begin
      if (reset_in) begin
         r_count <= 2'd0;
         r_head  <= 1'b0;
         r_tail  <= 1'b0;
      end else if (flush_in) begin
         r_count <= 2'd0;
         r_head  <= 1'b0;
         r_tail  <= 1'b0;
      end else begin
         if (w_push) r_tail <= ~r_tail;
         if (w_pop)  r_head <= ~r_head;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Buffer storage, written at the tail on each kept response.
   always_ff @(posedge clock_in or posedge reset_in) begin
      if (reset_in) begin
         r_buf_inst[0] <= 32'h0;
         r_buf_inst[1] <= 32'h0;
         r_buf_pc[0]   <= 32'h0;
         r_buf_pc[1]   <= 32'h0;
      end else if (w_push) begin
         r_buf_inst[r_tail] <= mem_rdata_in;
         r_buf_pc[r_tail]   <= r_pend_pc;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: simple 1-cycle memory model plus scoreboards
// of expected request addresses and expected decoded {pc, inst}.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        reset_in, flush_in, mem_gnt_in, mem_rvalid_in, id_ready_in;
   logic [31:0] flush_addr_in, mem_rdata_in;
   logic        mem_req_out, id_valid_out;
   logic [31:0] mem_addr_out, id_inst_out, id_pc_out;

   int          total = 0;
   int          bad   = 0;
   logic [31:0] exp_q  [$];
   logic [31:0] addr_q [$];
   logic        resp_pend = 1'b0;
   logic [31:0] resp_addr = 32'h0;
   logic        rv_block  = 1'b0;

   fetch_unit #(.RESET_ADDR(32'h0000_0000), .BUF_DEPTH(2)) dut (
      .clock_in(clk), .reset_in(reset_in), .flush_in(flush_in),
      .flush_addr_in(flush_addr_in), .mem_req_out(mem_req_out),
      .mem_addr_out(mem_addr_out), .mem_gnt_in(mem_gnt_in),
      .mem_rvalid_in(mem_rvalid_in), .mem_rdata_in(mem_rdata_in),
      .id_valid_out(id_valid_out), .id_inst_out(id_inst_out),
      .id_pc_out(id_pc_out), .id_ready_in(id_ready_in)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] word(input logic [31:0] a);
      return a ^ 32'hC0DE_5A00;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock: score pops/requests just before the edge, then update the
   // memory model on the falling edge (response exactly one cycle after grant).
   task automatic cyc();
      logic        acc;
      logic [31:0] a, e;
      #1;
      if (id_valid_out && id_ready_in) begin
         total++;
         assert (exp_q.size() != 0) else begin
            bad++;
            $error("FAIL pop_extra: observed pc=%h expected no instruction", id_pc_out);
         end
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("pop_pc", id_pc_out, e);
            chk("pop_inst", id_inst_out, word(e));
         end
      end
      acc = mem_req_out && mem_gnt_in;
      a   = mem_addr_out;
      if (acc) begin
         total++;
         assert (addr_q.size() != 0) else begin
            bad++;
            $error("FAIL req_extra: observed addr=%h expected no request", a);
         end
         if (addr_q.size() != 0) chk("req_addr", a, addr_q.pop_front());
      end
      if (mem_rvalid_in) resp_pend = 1'b0;
      @(posedge clk);
      @(negedge clk);
      if (acc) begin
         resp_pend = 1'b1;
         resp_addr = a;
      end
      mem_rvalid_in = resp_pend && !rv_block;
      mem_rdata_in  = mem_rvalid_in ? word(resp_addr) : 32'h0;
      #1;
   endtask

   initial begin
      reset_in = 1'b1; flush_in = 1'b0; flush_addr_in = 32'h0;
      mem_gnt_in = 1'b0; mem_rvalid_in = 1'b0; mem_rdata_in = 32'h0;
      id_ready_in = 1'b0;
      @(negedge clk);
      #1;
      chk("rst_req", {31'b0, mem_req_out}, 32'd0);
      chk("rst_addr", mem_addr_out, 32'h0);
      chk("rst_valid", {31'b0, id_valid_out}, 32'd0);
      chk("rst_inst", id_inst_out, 32'h0);
      chk("rst_pc", id_pc_out, 32'h0);

      // Streaming from reset, decode always ready.
      reset_in = 1'b0; mem_gnt_in = 1'b1; id_ready_in = 1'b1;
      addr_q.push_back(32'h0); addr_q.push_back(32'h4); addr_q.push_back(32'h8);
      exp_q.push_back(32'h0);  exp_q.push_back(32'h4);  exp_q.push_back(32'h8);
      cyc();
      chk("lat_n1_valid", {31'b0, id_valid_out}, 32'd0);
      cyc();
      chk("lat_n2_valid", {31'b0, id_valid_out}, 32'd1);
      repeat (3) cyc();
      mem_gnt_in = 1'b0;
      repeat (2) cyc();
      chk("A_exp_left", exp_q.size(), 32'd0);

      // Decode stalled: buffer fills to two, then requests stop.
      id_ready_in = 1'b0; mem_gnt_in = 1'b1;
      addr_q.push_back(32'hC); addr_q.push_back(32'h10); addr_q.push_back(32'h14);
      exp_q.push_back(32'hC);  exp_q.push_back(32'h10);  exp_q.push_back(32'h14);
      repeat (10) cyc();
      chk("B_full_req", {31'b0, mem_req_out}, 32'd0);
      chk("B_full_valid", {31'b0, id_valid_out}, 32'd1);
      chk("B_head_pc", id_pc_out, 32'hC);
      id_ready_in = 1'b1;
      cyc(); cyc();
      mem_gnt_in = 1'b0;
      cyc(); cyc();
      chk("B_exp_left", exp_q.size(), 32'd0);

      // Flush while waiting for a response: response is discarded.
      addr_q.push_back(32'h18);
      mem_gnt_in = 1'b1; rv_block = 1'b1;
      cyc();
      mem_gnt_in = 1'b0; flush_in = 1'b1; flush_addr_in = 32'h100;
      cyc();
      flush_in = 1'b0; rv_block = 1'b0;
      cyc(); cyc();
      chk("C_valid", {31'b0, id_valid_out}, 32'd0);
      chk("C_req", {31'b0, mem_req_out}, 32'd1);
      chk("C_addr", mem_addr_out, 32'h100);
      addr_q.push_back(32'h100); exp_q.push_back(32'h100);
      mem_gnt_in = 1'b1; cyc();
      mem_gnt_in = 1'b0; cyc(); cyc();
      chk("C_exp_left", exp_q.size(), 32'd0);

      // Flush in the same cycle as the response.
      addr_q.push_back(32'h104);
      mem_gnt_in = 1'b1; cyc();
      mem_gnt_in = 1'b0; flush_in = 1'b1; flush_addr_in = 32'h200;
      cyc();
      flush_in = 1'b0;
      #1;
      chk("D_valid", {31'b0, id_valid_out}, 32'd0);
      chk("D_req", {31'b0, mem_req_out}, 32'd1);
      chk("D_addr", mem_addr_out, 32'h200);
      addr_q.push_back(32'h200); exp_q.push_back(32'h200);
      mem_gnt_in = 1'b1; cyc();
      mem_gnt_in = 1'b0; cyc(); cyc();
      chk("D_exp_left", exp_q.size(), 32'd0);

      // Grant withheld: request held stable; misaligned redirect mid-stall.
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk("E_stall_req", {31'b0, mem_req_out}, 32'd1);
         chk("E_stall_addr", mem_addr_out, 32'h204);
      end
      flush_in = 1'b1; flush_addr_in = 32'h302;
      #1;
      chk("E_flush_noreq", {31'b0, mem_req_out}, 32'd0);
      cyc();
      flush_in = 1'b0;
      #1;
      chk("E_req", {31'b0, mem_req_out}, 32'd1);
      chk("E_addr", mem_addr_out, 32'h300);
      addr_q.push_back(32'h300); exp_q.push_back(32'h300);
      mem_gnt_in = 1'b1; cyc();
      mem_gnt_in = 1'b0; cyc(); cyc();
      chk("E_exp_left", exp_q.size(), 32'd0);

      // Reset while WAIT with one buffered entry; stale response afterwards.
      id_ready_in = 1'b0;
      addr_q.push_back(32'h304); addr_q.push_back(32'h308);
      mem_gnt_in = 1'b1;
      cyc(); cyc();
      rv_block = 1'b1;
      cyc();
      mem_gnt_in = 1'b0;
      chk("F_pre_valid", {31'b0, id_valid_out}, 32'd1);
      chk("F_pre_pc", id_pc_out, 32'h304);
      chk("F_pre_inst", id_inst_out, word(32'h304));
      reset_in = 1'b1; flush_in = 1'b1; flush_addr_in = 32'h500;
      #1;
      chk("F_rst_valid", {31'b0, id_valid_out}, 32'd0);
      chk("F_rst_pc", id_pc_out, 32'h0);
      chk("F_rst_inst", id_inst_out, 32'h0);
      chk("F_rst_req", {31'b0, mem_req_out}, 32'd0);
      chk("F_rst_addr", mem_addr_out, 32'h0);
      cyc();
      reset_in = 1'b0; flush_in = 1'b0; rv_block = 1'b0;
      cyc(); cyc();
      chk("F_stale_valid", {31'b0, id_valid_out}, 32'd0);
      chk("F_post_req", {31'b0, mem_req_out}, 32'd1);
      chk("F_post_addr", mem_addr_out, 32'h0);
      id_ready_in = 1'b1;
      addr_q.push_back(32'h0); exp_q.push_back(32'h0);
      mem_gnt_in = 1'b1; cyc();
      mem_gnt_in = 1'b0; cyc(); cyc();
      chk("F_exp_left", exp_q.size(), 32'd0);
      chk("F_addr_left", addr_q.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: FETCH_UNIT

Interface
REQ-001 Parameter RESET_ADDR, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 Parameter BUF_DEPTH, default 2, SHALL be the instruction buffer depth; only the value 2 is supported.
REQ-003 clock_in  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 reset_in  input  1  SHALL be an asynchronous, active-high reset.
REQ-005 flush_in  input  1  SHALL be the IF-stage pipeline reset bit from CONTROL; high means redirect fetch.
REQ-006 flush_addr_in  input  32  SHALL be the redirect target, sampled when flush_in=1.
REQ-007 mem_req_out  output  1  SHALL be the instruction memory request.
REQ-008 mem_addr_out  output  32  SHALL be the request address, word aligned.
REQ-009 mem_gnt_in  input  1  SHALL be the grant; req&gnt in one cycle means the request is accepted.
REQ-010 mem_rvalid_in  input  1  SHALL mark mem_rdata_in valid; earliest one cycle after grant.
REQ-011 mem_rdata_in  input  32  SHALL be the returned instruction word.
REQ-012 id_valid_out  output  1  SHALL mean id_inst_out/id_pc_out hold a valid instruction.
REQ-013 id_inst_out  output  32  SHALL be the instruction at buffer head.
REQ-014 id_pc_out  output  32  SHALL be the PC of id_inst_out.
REQ-015 id_ready_in  input  1  SHALL mean decode accepts the head entry this cycle.

Function
REQ-016 The FSM SHALL have states REQ, WAIT, DISCARD; at most one memory request outstanding.
REQ-017 In REQ, mem_req_out SHALL equal (count<2) and mem_addr_out SHALL equal pc_q; otherwise mem_req_out=0.
REQ-018 REQ with req&gnt and no flush SHALL: latch pc_q into pend_pc, pc_q<=pc_q+4 (mod 2^32 wrap), go WAIT.
REQ-019 WAIT with rvalid and no flush SHALL push {pend_pc, mem_rdata_in} into the buffer and go REQ.
REQ-020 DISCARD SHALL drop the response on rvalid (no push) and go REQ.
REQ-021 mem_rvalid_in in REQ SHALL be ignored.
REQ-022 flush_in=1 SHALL, next cycle: pc_q<=flush_addr_in, buffer count<=0, id_valid_out=0, regardless of state.
REQ-023 Flush state rule: from REQ with gnt same cycle -> DISCARD; REQ without gnt -> REQ; WAIT without rvalid -> DISCARD; WAIT with rvalid -> REQ (response dropped); DISCARD without rvalid -> DISCARD; DISCARD with rvalid -> REQ.
REQ-024 A flush cycle SHALL NOT issue a request from the old pc_q; mem_req_out is forced 0 while flush_in=1.
REQ-025 The buffer SHALL be a 2-entry FIFO with head/tail pointers wrapping modulo 2 and a 2-bit count.
REQ-026 id_valid_out SHALL equal (count!=0); id_inst_out/id_pc_out SHALL be the head entry, registered.
REQ-027 Pop SHALL occur when id_valid_out&id_ready_in; simultaneous push and pop SHALL keep count unchanged.
REQ-028 Push at count=2 SHALL be impossible by construction (REQ-017); pop at count=0 SHALL be ignored.
REQ-029 Latency: gnt in cycle N, rvalid in N+1 -> id_valid_out=1 in N+2; peak rate one instruction per 2 cycles.
REQ-030 flush_addr_in bits [1:0] SHALL be forced to 0 when loaded into pc_q.

Reset
REQ-031 reset_in=1 SHALL immediately set: state REQ, pc_q=RESET_ADDR, pend_pc=0, count=0, pointers=0.
REQ-032 During reset, mem_req_out=0, mem_addr_out=RESET_ADDR, id_valid_out=0, id_inst_out=0, id_pc_out=0.
REQ-033 Reset asserted mid-transaction SHALL abandon the outstanding request; a stale rvalid after release, arriving in REQ, is ignored per REQ-021.
REQ-034 flush_in during reset SHALL have no effect.

Verification
REQ-035 Reset release, gnt=1 always, rvalid 1 cycle after gnt, ready=1 -> addresses 0x0,0x4,0x8; id_pc_out 0x0,0x4,0x8 with matching words.
REQ-036 ready=0 for 10 cycles -> exactly 2 entries buffered, mem_req_out=0 afterwards; ready=1 -> entries drained in order, fetch resumes at 0x8.
REQ-037 Flush to 0x100 while WAIT for 0x4 -> response for 0x4 dropped, next mem_addr_out=0x100, first id_pc_out=0x100.
REQ-038 flush_in and rvalid same cycle -> no push, state REQ, next request at flush target 0x200.
REQ-039 gnt held low 5 cycles -> mem_req_out stays 1, mem_addr_out stable; flush_addr_in=0x302 mid-stall -> pc becomes 0x300.
REQ-040 reset_in pulsed while WAIT with count=1 -> outputs cleared asynchronously; restart from RESET_ADDR.
